// File: rtl/aes_pkg.sv
// Shared AES types, S-box and key-schedule helpers.
// Used by the iterative encrypt core and its round datapath.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } aes_state_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // One case entry per high nibble; the low nibble picks the byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        row = '0;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]),  sbox(w[7:0])};
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Four chained words of the expansion; t is the transformed seed.
    function automatic aes_block_t ks_step(input aes_block_t a,
                                           input aes_word_t  t);
        aes_word_t w0, w1, w2, w3;
        w0 = a[127:96] ^ t;
        w1 = a[95:64]  ^ w0;
        w2 = a[63:32]  ^ w1;
        w3 = a[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_core_param_if.sv
// Valid/ready bundle between a block source/sink and the AES core.
// master drives plaintext and accepts ciphertext; slave is the core.
interface aes_core_param_if #(
    parameter int KEY_BITS = 128
);
    logic [KEY_BITS-1:0] pi_key;
    logic [127:0]        pi_data;
    logic                pi_valid;
    logic                po_ready;
    logic [127:0]        po_data;
    logic                po_valid;
    logic                pi_ready;
    logic                po_busy;

    modport master (
        output pi_key, pi_data, pi_valid, pi_ready,
        input  po_ready, po_data, po_valid, po_busy
    );

    modport slave (
        input  pi_key, pi_data, pi_valid, pi_ready,
        output po_ready, po_data, po_valid, po_busy
    );
endinterface

// File: rtl/aes_round.sv
// One combinational AES encrypt round.
// final_rnd drops MixColumns for the last round.
module aes_round
    import aes_pkg::*;
(
    input  aes_block_t st,
    input  aes_block_t rk,
    input  logic       final_rnd,
    output aes_block_t res
);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        res = '0;
        a0  = '0;
        a1  = '0;
        a2  = '0;
        a3  = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(st[127-8*i -: 8]);
        end
        // Row r of output column c comes from column (c+r)%4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int i = 0; i < 16; i++) begin
            res[127-8*i -: 8] = (final_rnd ? sr[i] : mc[i])
                              ^ rk[127-8*i -: 8];
        end
    end
endmodule

// File: rtl/aes_core_param.sv
// Iterative AES-128/256 encrypt core, one round per clock.
// Round keys are expanded on the fly from a registered key window.
module aes_core_param
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input logic             pi_clk,
    input logic             pi_rst,
    aes_core_param_if.slave bus
);
    localparam int         NR   = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] NR_L = NR[3:0];

    aes_state_e          state, state_nxt;
    aes_block_t          st, data_q, rk, round_res;
    logic [KEY_BITS-1:0] key_reg, key_nxt;
    logic [3:0]          rnd, ri;
    aes_word_t           t;
    logic                last;

    assign last        = (rnd == NR_L);
    assign bus.po_data = data_q;

    generate
        if (KEY_BITS == 256) begin : g_ks256
            aes_block_t a, b, n;
            // Window is {rk[r-2], rk[r-1]}; round 1 uses the raw key half.
            always_comb begin
                a  = key_reg[255:128];
                b  = key_reg[127:0];
                ri = (rnd[3:1] != 3'd0) ? {1'b0, rnd[3:1]} - 4'd1 : 4'd0;
                t  = rnd[0] ? sub_word(b[31:0])
                            : sub_word(rot_word(b[31:0])) ^ {RCON[ri], 24'h0};
                n  = ks_step(a, t);
                if (rnd == 4'd1) begin
                    rk      = b;
                    key_nxt = key_reg;
                end else begin
                    rk      = n;
                    key_nxt = {b, n};
                end
            end
        end else if (KEY_BITS == 128) begin : g_ks128
            always_comb begin
                ri      = (rnd != 4'd0) ? rnd - 4'd1 : 4'd0;
                t       = sub_word(rot_word(key_reg[31:0])) ^ {RCON[ri], 24'h0};
                rk      = ks_step(key_reg, t);
                key_nxt = rk;
            end
        end else begin : g_bad
            $error("aes_core_param: KEY_BITS must be 128 or 256");
        end
    endgenerate

    aes_round u_round (
        .st       (st),
        .rk       (rk),
        .final_rnd(last),
        .res      (round_res)
    );

    always_ff @(posedge pi_clk) begin
        if (pi_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (bus.pi_valid) state_nxt = ST_ROUND;
            ST_ROUND: if (last)         state_nxt = ST_DONE;
            ST_DONE:  if (bus.pi_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.po_ready = 1'b0;
        bus.po_valid = 1'b0;
        bus.po_busy  = 1'b0;
        unique case (state)
            ST_IDLE:  bus.po_ready = 1'b1;
            ST_ROUND: bus.po_busy  = 1'b1;
            ST_DONE: begin
                bus.po_valid = 1'b1;
                bus.po_busy  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            st      <= '0;
            key_reg <= '0;
            rnd     <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.pi_valid) begin
                        st      <= bus.pi_data ^ bus.pi_key[KEY_BITS-1 -: 128];
                        key_reg <= bus.pi_key;
                        rnd     <= 4'd1;
                    end
                end
                ST_ROUND: begin
                    st      <= round_res;
                    key_reg <= key_nxt;
                    // rnd parks at NR until the output handshake.
                    if (last) data_q <= round_res;
                    else      rnd    <= rnd + 4'd1;
                end
                ST_DONE: begin
                    if (bus.pi_ready) rnd <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core_param.sv
// Scoreboard bench for aes_core_param (AES-128 and AES-256 instances).
// Directed FIPS-197 vectors, backpressure, reset abort and back-to-back.
module tb_aes_core_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_core_param_if #(.KEY_BITS(128)) bus128 ();
    aes_core_param_if #(.KEY_BITS(256)) bus256 ();

    aes_core_param #(.KEY_BITS(128)) dut128 (
        .pi_clk(clk),
        .pi_rst(rst),
        .bus   (bus128.slave)
    );

    aes_core_param #(.KEY_BITS(256)) dut256 (
        .pi_clk(clk),
        .pi_rst(rst),
        .bus   (bus256.slave)
    );

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] exp128 [$];
    logic [127:0] exp256 [$];
    int           acc128 [$];
    int           acc256 [$];
    logic         pv128 = 1'b0;
    logic         pv256 = 1'b0;
    int           a128, a256;

    function automatic void chk(string name, logic [127:0] got,
                                logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endfunction

    // Monitors: accepts, latency to po_valid, and ciphertext on handshake.
    always @(negedge clk) begin
        if (rst) begin
            pv128 <= 1'b0;
        end else begin
            if (bus128.po_ready && bus128.pi_valid) acc128.push_back(cyc + 1);
            if (bus128.po_valid && !pv128) begin
                if (acc128.size() == 0) begin
                    chk("acc128_missing", 128'd0, 128'd1);
                end else begin
                    a128 = acc128.pop_front();
                    chk("lat128", 128'(cyc - a128), 128'd10);
                end
            end
            if (bus128.po_valid && bus128.pi_ready) begin
                if (exp128.size() == 0) chk("ct128_unexpected", bus128.po_data, 128'hx);
                else                    chk("ct128", bus128.po_data, exp128.pop_front());
            end
            pv128 <= bus128.po_valid;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv256 <= 1'b0;
        end else begin
            if (bus256.po_ready && bus256.pi_valid) acc256.push_back(cyc + 1);
            if (bus256.po_valid && !pv256) begin
                if (acc256.size() == 0) begin
                    chk("acc256_missing", 128'd0, 128'd1);
                end else begin
                    a256 = acc256.pop_front();
                    chk("lat256", 128'(cyc - a256), 128'd14);
                end
            end
            if (bus256.po_valid && bus256.pi_ready) begin
                if (exp256.size() == 0) chk("ct256_unexpected", bus256.po_data, 128'hx);
                else                    chk("ct256", bus256.po_data, exp256.pop_front());
            end
            pv256 <= bus256.po_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send128(input logic [127:0] k, input logic [127:0] pt,
                           input logic [127:0] ct, input bit expect_out);
        int n = 0;
        tick();
        while (!bus128.po_ready && n < 40) begin
            tick();
            n++;
        end
        chk("send128_ready", 128'(bus128.po_ready), 128'd1);
        bus128.pi_key   = k;
        bus128.pi_data  = pt;
        bus128.pi_valid = 1'b1;
        if (expect_out) exp128.push_back(ct);
        tick();
        bus128.pi_valid = 1'b0;
    endtask

    task automatic send256(input logic [255:0] k, input logic [127:0] pt,
                           input logic [127:0] ct);
        int n = 0;
        tick();
        while (!bus256.po_ready && n < 40) begin
            tick();
            n++;
        end
        chk("send256_ready", 128'(bus256.po_ready), 128'd1);
        bus256.pi_key   = k;
        bus256.pi_data  = pt;
        bus256.pi_valid = 1'b1;
        exp256.push_back(ct);
        tick();
        bus256.pi_valid = 1'b0;
    endtask

    task automatic drain128();
        int n = 0;
        while ((exp128.size() != 0 || bus128.po_busy) && n < 60) begin
            tick();
            n++;
        end
        chk("drain128", 128'(exp128.size()), 128'd0);
    endtask

    task automatic drain256();
        int n = 0;
        while ((exp256.size() != 0 || bus256.po_busy) && n < 60) begin
            tick();
            n++;
        end
        chk("drain256", 128'(exp256.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g1, g2;
        bus128.pi_key   = '0;
        bus128.pi_data  = '0;
        bus128.pi_valid = 1'b0;
        bus128.pi_ready = 1'b1;
        bus256.pi_key   = '0;
        bus256.pi_data  = '0;
        bus256.pi_valid = 1'b0;
        bus256.pi_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready128", 128'(bus128.po_ready), 128'd1);
        chk("rst_valid128", 128'(bus128.po_valid), 128'd0);
        chk("rst_busy128",  128'(bus128.po_busy),  128'd0);
        chk("rst_data128",  bus128.po_data,        128'd0);
        chk("rst_ready256", 128'(bus256.po_ready), 128'd1);
        chk("rst_valid256", 128'(bus256.po_valid), 128'd0);
        chk("rst_data256",  bus256.po_data,        128'd0);

        // T1, T2: AES-128 vectors
        send128(K1, P1, C1, 1'b1);
        drain128();
        send128(K2, P2, C2, 1'b1);
        drain128();

        // T3: AES-256 vector
        send256(K3, P2, C3);
        drain256();

        // T4: backpressure in DONE with an ignored pi_valid pulse
        bus128.pi_ready = 1'b0;
        send128(K1, P1, C1, 1'b1);
        n = 0;
        while (!bus128.po_valid && n < 30) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", 128'(bus128.po_valid), 128'd1);
            chk("t4_data",  bus128.po_data,        C1);
            chk("t4_ready", 128'(bus128.po_ready), 128'd0);
            if (i == 2) begin
                bus128.pi_key   = K2;
                bus128.pi_data  = P2;
                bus128.pi_valid = 1'b1;
            end
            if (i == 3) bus128.pi_valid = 1'b0;
            tick();
        end
        chk("t4_busy", 128'(bus128.po_busy), 128'd1);
        bus128.pi_ready = 1'b1;
        tick();
        chk("t4_valid_fall", 128'(bus128.po_valid), 128'd0);
        chk("t4_ready_rise", 128'(bus128.po_ready), 128'd1);
        chk("t4_data_hold",  bus128.po_data,        C1);
        chk("t4_sb_empty",   128'(exp128.size()),   128'd0);

        // T5: reset while round 5 of T2 is in flight
        send128(K2, P2, C2, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("t5_ready", 128'(bus128.po_ready), 128'd1);
        chk("t5_valid", 128'(bus128.po_valid), 128'd0);
        chk("t5_busy",  128'(bus128.po_busy),  128'd0);
        chk("t5_data",  bus128.po_data,        128'd0);
        rst = 1'b0;
        acc128.delete();
        send128(K2, P2, C2, 1'b1);
        drain128();

        // T6: pi_valid held high, T1 then T2 back to back
        tick();
        bus128.pi_key   = K1;
        bus128.pi_data  = P1;
        bus128.pi_valid = 1'b1;
        exp128.push_back(C1);
        n = 0;
        while (!bus128.po_ready && n < 40) begin
            tick();
            n++;
        end
        g1 = cyc;
        tick();
        bus128.pi_key  = K2;
        bus128.pi_data = P2;
        exp128.push_back(C2);
        n = 0;
        while (!bus128.po_ready && n < 40) begin
            tick();
            n++;
        end
        g2 = cyc;
        tick();
        bus128.pi_valid = 1'b0;
        chk("t6_gap", 128'(g2 - g1), 128'd12);
        drain128();
        chk("t6_acc_empty", 128'(acc128.size()), 128'd0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
